// File: rtl/weight_mem_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// weight_mem_sequencer : load/read sequencer for the signed weight memory
// Rev 1.0
// ============================================================================
module weight_mem_sequencer #(
  parameter int DEPTH = 30,
  parameter int DW    = 9,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          load_done,
  input  logic          rd_start,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic          mem_read,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      load_done <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      // Memory read data appears one cycle after the issue, so valid/last track it.
      rd_valid  <= (state == READ);
      rd_last   <= (state == READ) && (cnt == LAST_ADDR);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (load_start)    state <= LOAD;
          else if (rd_start) state <= READ;
        end
        LOAD: begin
          if (wr_valid) begin
            if (cnt == LAST_ADDR) begin
              state     <= IDLE;
              cnt       <= '0;
              load_done <= 1'b1;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        READ: begin
          if (cnt == LAST_ADDR) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        DRAIN: state <= IDLE;
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign wr_ready   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign mem_read   = (state == READ);
  assign mem_write  = wr_ready && wr_valid;
  assign mem_addr   = (mem_read || mem_write) ? cnt : '0;
  assign mem_datain = mem_write ? wr_data : '0;
  assign rd_data    = mem_dataout;

endmodule
`default_nettype wire

// File: tb/tb_weight_mem_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_weight_mem_sequencer : bench with behavioural weight memory and scoreboards
// Rev 1.0
// ============================================================================
module tb_weight_mem_sequencer;
  localparam int DEPTH = 30;
  localparam int DW    = 9;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load_start = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_start = 1'b0;
  logic          wr_ready, load_done, rd_valid, rd_last, busy;
  logic [DW-1:0] rd_data, mem_datain;
  logic [DW-1:0] mem_dataout = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_write, mem_read;

  always #5 clk = ~clk;

  weight_mem_sequencer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .load_done(load_done),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  // Weight memory: registered read, zero output when read is low.
  logic [DW-1:0] mem [0:31];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_datain;
    mem_dataout <= mem_read ? mem[mem_addr] : '0;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int data; bit last; } rd_t;
  typedef struct { int base; bit gap; bit both; int exp_writes; int exp_done; } vec_t;

  wr_t wq[$];
  rd_t rq[$];
  wr_t mon_w;
  rd_t mon_r;
  int  exp_mem [DEPTH];
  int  nwrites = 0, ndone = 0, nread_out = 0, exp_raddr = 0;
  bit  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (mem_write || mem_read) begin
        chk("rw_exclusive", mem_write && mem_read, 0);
        chk("addr_range", mem_addr < AW'(DEPTH), 1);
      end
      if (mem_write) begin
        nwrites++;
        chk("write_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          mon_w = wq.pop_front();
          chk("wr_addr", mem_addr, mon_w.addr);
          chk("wr_data", $signed(mem_datain), mon_w.data);
        end
      end
      if (mem_read) begin
        chk("rd_addr", mem_addr, exp_raddr);
        exp_raddr = (exp_raddr == DEPTH - 1) ? 0 : exp_raddr + 1;
      end
      if (load_done) ndone++;
      if (rd_valid) begin
        nread_out++;
        chk("rd_expected", rq.size() > 0, 1);
        if (rq.size() > 0) begin
          mon_r = rq.pop_front();
          chk("rd_data", $signed(rd_data), mon_r.data);
          chk("rd_last", rd_last, mon_r.last);
        end
      end else begin
        chk("rd_last_without_valid", rd_last, 0);
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_datain", mem_datain, 0);
    wq.delete();
    rq.delete();
    exp_raddr = 0;
    load_start = 1'b0; rd_start = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic load_pass(input int base, input bit gap, input bit both);
    nwrites = 0;
    ndone = 0;
    @(posedge clk); #1;
    load_start = 1'b1;
    rd_start = both;
    @(posedge clk); #1;
    load_start = 1'b0;
    rd_start = 1'b0;
    chk("load_busy", busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("wr_ready", wr_ready, 1);
      chk("no_read_in_load", mem_read, 0);
      wr_valid = 1'b1;
      wr_data = DW'(base + i);
      wq.push_back('{i, base + i});
      exp_mem[i] = base + i;
      if (both && i == 5) rd_start = 1'b1;
      @(posedge clk); #1;
      rd_start = 1'b0;
      if (gap && i != DEPTH - 1) begin
        wr_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    wr_valid = 1'b0;
    chk("load_done_pulse", load_done, 1);
    chk("idle_after_load", busy, 0);
    chk("wr_ready_low", wr_ready, 0);
    @(posedge clk); #1;
    chk("load_done_clear", load_done, 0);
    chk("no_read_after_load", mem_read, 0);
    chk("still_idle", busy, 0);
  endtask

  task automatic read_pass(input int abort_at);
    nread_out = 0;
    for (int i = 0; i < DEPTH; i++) rq.push_back('{exp_mem[i], i == DEPTH - 1});
    @(posedge clk); #1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    chk("rd_latency_early", rd_valid, 0);
    chk("read_busy", busy, 1);
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1;
      chk("rd_valid_run", rd_valid, 1);
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mem_read", mem_read, 0);
        chk("abort_words_seen", nread_out, abort_at);
        rq.delete();
        exp_raddr = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        return;
      end
      if (k == DEPTH - 1) chk("drain_busy", busy, 1);
    end
    @(posedge clk); #1;
    chk("rd_valid_end", rd_valid, 0);
    chk("busy_end", busy, 0);
    chk("rd_queue_empty", rq.size(), 0);
    chk("rd_count", nread_out, DEPTH);
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{-10,  1'b0, 1'b0, DEPTH, 1};
    vecs[1] = '{100,  1'b1, 1'b0, DEPTH, 1};
    vecs[2] = '{50,   1'b0, 1'b1, DEPTH, 1};
    vecs[3] = '{-200, 1'b1, 1'b1, DEPTH, 1};

    apply_reset();
    mon_en = 1'b1;

    for (int v = 0; v < 4; v++) begin
      load_pass(vecs[v].base, vecs[v].gap, vecs[v].both);
      chk("write_count", nwrites, vecs[v].exp_writes);
      chk("done_count", ndone, vecs[v].exp_done);
      read_pass(-1);
    end

    // Abort a read at word 12, then a fresh pass must restart from address 0.
    read_pass(12);
    read_pass(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
